dmem_port_arbiter: RTL and testbench

//  Shares the single-port data memory between two requesters: port 0 is the core load/store unit, port 1 is the debug/DMA loader.

---
 rtl/dmem_port_arbiter_pkg.sv | 13 +
 rtl/dmem_port_arbiter_if.sv | 21 ++
 rtl/dmem_port_arbiter_rr_arb2.sv | 22 ++
 rtl/dmem_port_arbiter.sv | 94 +++++++++
 tb/tb_dmem_port_arbiter.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_port_arbiter_pkg.sv
// dmem_port_arbiter_pkg: shared state encoding and port-id helpers for the data memory port arbiter
package dmem_port_arbiter_pkg;
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_COMPLETE = 2'd2
  } arb_state_e;
  localparam int PID_W = 1;
  typedef logic [PID_W-1:0] pid_t;
  function automatic logic [1:0] pid2oh(input pid_t id);
    return id[0] ? 2'b10 : 2'b01;
  endfunction
endpackage

// File: rtl/dmem_port_arbiter_if.sv
// dmem_port_if: one requester's valid/ready request channel plus its one-cycle response pulse
interface dmem_port_if #(
  parameter int AW = 16,
  parameter int DW = 16
) ();
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/dmem_port_arbiter_rr_arb2.sv
// rr_arb2: two-way arbiter with a 1-bit priority pointer, fixed-priority option, one-hot grant
module rr_arb2 #(
  parameter int FIXED_PRIO = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);
  logic ptr_q, ptr_d;
  logic pick1;
  always_comb begin
    pick1 = req_i[1] && (!req_i[0] || (FIXED_PRIO == 0 && ptr_q));
    gnt_o = en_i ? {pick1, req_i[0] && !pick1} : 2'b00;
    ptr_d = gnt_o[0] ? 1'b1 : gnt_o[1] ? 1'b0 : ptr_q;
  end
  always_ff @(posedge clk) begin
    if (rst) ptr_q <= 1'b0;
    else     ptr_q <= ptr_d;
  end
endmodule

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares the registered-address data memory between the LSU (p0) and the debug/DMA loader (p1)
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int AW         = 16,
  parameter int DW         = 16,
  parameter int FIXED_PRIO = 0
) (
  input  logic          clk,
  input  logic          rst,
  dmem_port_if.slave    p0,
  dmem_port_if.slave    p1,
  output logic [AW-1:0] mem_addr_o,
  output logic          mem_read_en_o,
  output logic          mem_write_en_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i
);
  arb_state_e    st_q, st_d;
  logic [1:0]    gnt;
  logic          acc, acc_en, done;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  pid_t          id_q, id_d;
  logic [1:0]    rsp_v_q, rsp_v_d;
  logic [DW-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

  assign acc_en = !rst && st_q != ST_ISSUE;
  assign acc    = |gnt;
  assign done   = st_q == ST_COMPLETE;

  rr_arb2 #(.FIXED_PRIO(FIXED_PRIO)) u_arb (
    .clk   (clk),
    .rst   (rst),
    .en_i  (acc_en),
    .req_i ({p1.req_valid, p0.req_valid}),
    .gnt_o (gnt)
  );

  assign p0.req_ready = gnt[0];
  assign p1.req_ready = gnt[1];
  assign p0.rsp_valid = rsp_v_q[0];
  assign p1.rsp_valid = rsp_v_q[1];
  assign p0.rsp_rdata = rdata0_q;
  assign p1.rsp_rdata = rdata1_q;

  always_ff @(posedge clk) begin
    if (rst) st_q <= ST_IDLE;
    else     st_q <= st_d;
  end

  always_comb begin
    st_d = acc ? ST_ISSUE : st_q == ST_ISSUE ? ST_COMPLETE : ST_IDLE;
  end

  // The write strobe is gated by rst so a write caught by reset in COMPLETE never commits.
  always_comb begin
    mem_addr_o     = addr_q;
    mem_wdata_o    = wdata_q;
    mem_read_en_o  = done && !we_q;
    mem_write_en_o = done && we_q && !rst;
  end

  always_comb begin
    id_d     = acc ? pid_t'(gnt[1]) : id_q;
    we_d     = acc ? (gnt[1] ? p1.req_we : p0.req_we) : we_q;
    addr_d   = acc ? (gnt[1] ? p1.req_addr : p0.req_addr) : addr_q;
    wdata_d  = acc ? (gnt[1] ? p1.req_wdata : p0.req_wdata) : wdata_q;
    rsp_v_d  = done ? pid2oh(id_q) : 2'b00;
    rdata0_d = (done && !we_q && id_q == pid_t'(0)) ? mem_rdata_i : rdata0_q;
    rdata1_d = (done && !we_q && id_q == pid_t'(1)) ? mem_rdata_i : rdata1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      id_q     <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rsp_v_q  <= 2'b00;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      id_q     <= id_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rsp_v_q  <= rsp_v_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: directed checks of a round-robin and a fixed-priority arbiter against a registered-address memory model
module tb_dmem_port_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mem_init = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;

  dmem_port_if #(.AW(16), .DW(16)) a0 (), a1 (), b0 (), b1 ();
  logic [15:0] addr_a, wdata_a, rdata_a, addr_b, wdata_b, rdata_b;
  logic        re_a, we_a, re_b, we_b;

  dmem_port_arbiter #(.AW(16), .DW(16), .FIXED_PRIO(0)) dut_rr (
    .clk(clk), .rst(rst), .p0(a0), .p1(a1),
    .mem_addr_o(addr_a), .mem_read_en_o(re_a), .mem_write_en_o(we_a),
    .mem_wdata_o(wdata_a), .mem_rdata_i(rdata_a)
  );
  dmem_port_arbiter #(.AW(16), .DW(16), .FIXED_PRIO(1)) dut_fp (
    .clk(clk), .rst(rst), .p0(b0), .p1(b1),
    .mem_addr_o(addr_b), .mem_read_en_o(re_b), .mem_write_en_o(we_b),
    .mem_wdata_o(wdata_b), .mem_rdata_i(rdata_b)
  );

  // Memory model: address registered at each edge, read data from the registered address, write commits at the edge.
  logic [15:0] mem_a [256];
  logic [15:0] mem_b [256];
  logic [15:0] ma_q, mb_q;
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) begin
        mem_a[i] <= 16'h1000 + 16'(i);
        mem_b[i] <= 16'h1000 + 16'(i);
      end
      ma_q <= 16'h0;
      mb_q <= 16'h0;
    end else begin
      ma_q <= addr_a;
      mb_q <= addr_b;
      if (we_a) mem_a[ma_q[7:0]] <= wdata_a;
      if (we_b) mem_b[mb_q[7:0]] <= wdata_b;
    end
  end
  assign rdata_a = mem_a[ma_q[7:0]];
  assign rdata_b = mem_b[mb_q[7:0]];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    {a0.req_valid, a0.req_we, a0.req_addr, a0.req_wdata} = '0;
    {a1.req_valid, a1.req_we, a1.req_addr, a1.req_wdata} = '0;
    {b0.req_valid, b0.req_we, b0.req_addr, b0.req_wdata} = '0;
    {b1.req_valid, b1.req_we, b1.req_addr, b1.req_wdata} = '0;
    repeat (2) tick();
    mem_init = 1'b0;
    a0.req_valid = 1'b1; a1.req_valid = 1'b1;
    #1;
    chk("rst_ready0", a0.req_ready, 0);
    chk("rst_ready1", a1.req_ready, 0);
    tick();
    rst = 1'b0;
    a0.req_valid = 1'b0; a1.req_valid = 1'b0;
    #1;
    chk("rst_rsp0_valid", a0.rsp_valid, 0);
    chk("rst_rsp1_valid", a1.rsp_valid, 0);
    chk("rst_rdata0", a0.rsp_rdata, 0);
    chk("rst_rdata1", a1.rsp_rdata, 0);
    chk("rst_mem_addr", addr_a, 0);
    chk("rst_read_en", re_a, 0);
    chk("rst_write_en", we_a, 0);
    // round-robin with both ports reading continuously
    a0.req_valid = 1'b1; a0.req_addr = 16'h0004;
    a1.req_valid = 1'b1; a1.req_addr = 16'h0008;
    #1;
    chk("rr1_ready0", a0.req_ready, 1);
    chk("rr1_ready1", a1.req_ready, 0);
    tick();
    chk("rr_issue_ready0", a0.req_ready, 0);
    chk("rr_issue_ready1", a1.req_ready, 0);
    chk("rr_issue_addr", addr_a, 16'h0004);
    chk("rr_issue_read_en", re_a, 0);
    tick();
    chk("rr2_ready1", a1.req_ready, 1);
    chk("rr2_ready0", a0.req_ready, 0);
    chk("rr_complete_read_en", re_a, 1);
    tick();
    chk("rr_rsp0_valid", a0.rsp_valid, 1);
    chk("rr_rsp0_rdata", a0.rsp_rdata, 16'h1004);
    chk("rr_rsp1_idle", a1.rsp_valid, 0);
    tick();
    chk("rr3_ready0", a0.req_ready, 1);
    chk("rr3_ready1", a1.req_ready, 0);
    chk("rr_rsp0_pulse", a0.rsp_valid, 0);
    tick();
    chk("rr_rsp1_valid", a1.rsp_valid, 1);
    chk("rr_rsp1_rdata", a1.rsp_rdata, 16'h1008);
    chk("rr_rsp0_quiet", a0.rsp_valid, 0);
    a0.req_valid = 1'b0; a1.req_valid = 1'b0;
    tick();
    tick();
    chk("rr_rsp0_third", a0.rsp_valid, 1);
    chk("rr_rsp1_third", a1.rsp_valid, 0);
    tick();
    // port 1 write interrupted by reset in COMPLETE
    a1.req_valid = 1'b1; a1.req_we = 1'b1; a1.req_addr = 16'h0020; a1.req_wdata = 16'h1234;
    #1;
    chk("rstw_ready1", a1.req_ready, 1);
    tick();
    a1.req_valid = 1'b0;
    tick();
    rst = 1'b1;
    a0.req_valid = 1'b1; a1.req_valid = 1'b1;
    #1;
    chk("rstw_write_gated", we_a, 0);
    chk("rstw_ready0", a0.req_ready, 0);
    chk("rstw_ready1_low", a1.req_ready, 0);
    tick();
    rst = 1'b0;
    a0.req_valid = 1'b0;
    a1.req_valid = 1'b1; a1.req_we = 1'b0; a1.req_addr = 16'h0020;
    #1;
    chk("rstw_no_rsp1", a1.rsp_valid, 0);
    chk("rstw_rdata0_cleared", a0.rsp_rdata, 0);
    chk("rstw_read_ready1", a1.req_ready, 1);
    tick();
    a1.req_valid = 1'b0;
    tick();
    tick();
    chk("rstw_rsp1_valid", a1.rsp_valid, 1);
    chk("rstw_orig_data", a1.rsp_rdata, 16'h1020);
    // port 0 write then read of 0x0010
    a0.req_valid = 1'b1; a0.req_we = 1'b1; a0.req_addr = 16'h0010; a0.req_wdata = 16'hBEEF;
    #1;
    chk("wr_ready0", a0.req_ready, 1);
    tick();
    a0.req_valid = 1'b0;
    chk("wr_issue_no_we", we_a, 0);
    tick();
    chk("wr_complete_we", we_a, 1);
    chk("wr_wdata", wdata_a, 16'hBEEF);
    chk("wr_addr", addr_a, 16'h0010);
    tick();
    chk("wr_rsp0_valid", a0.rsp_valid, 1);
    chk("wr_rdata_held", a0.rsp_rdata, 0);
    a0.req_valid = 1'b1; a0.req_we = 1'b0;
    tick();
    a0.req_valid = 1'b0;
    tick();
    chk("rd_read_en", re_a, 1);
    tick();
    chk("rd_rsp0_valid", a0.rsp_valid, 1);
    chk("rd_rdata_beef", a0.rsp_rdata, 16'hBEEF);
    // back-to-back write then read of 0x0001
    a0.req_valid = 1'b1; a0.req_we = 1'b1; a0.req_addr = 16'h0001; a0.req_wdata = 16'h00AA;
    tick();
    a0.req_we = 1'b0;
    #1;
    chk("b2b_issue_ready0", a0.req_ready, 0);
    chk("b2b_issue_no_we", we_a, 0);
    tick();
    chk("b2b_complete_we", we_a, 1);
    chk("b2b_accept_in_complete", a0.req_ready, 1);
    tick();
    chk("b2b_issue2_no_we", we_a, 0);
    chk("b2b_wr_rsp", a0.rsp_valid, 1);
    a0.req_valid = 1'b0;
    tick();
    chk("b2b_mem_rdata", rdata_a, 16'h00AA);
    tick();
    chk("b2b_rsp0_valid", a0.rsp_valid, 1);
    chk("b2b_rdata", a0.rsp_rdata, 16'h00AA);
    // reset restores port-0 preference after a port-0 grant
    rst = 1'b1;
    tick();
    rst = 1'b0;
    a0.req_valid = 1'b1; a0.req_addr = 16'h0004;
    a1.req_valid = 1'b1; a1.req_addr = 16'h0008;
    #1;
    chk("post_rst_ready0", a0.req_ready, 1);
    chk("post_rst_ready1", a1.req_ready, 0);
    chk("post_rst_rdata0", a0.rsp_rdata, 0);
    chk("post_rst_rsp0", a0.rsp_valid, 0);
    tick();
    a0.req_valid = 1'b0; a1.req_valid = 1'b0;
    tick();
    tick();
    chk("post_rst_rsp0_valid", a0.rsp_valid, 1);
    chk("post_rst_rsp0_rdata", a0.rsp_rdata, 16'h1004);
    chk("post_rst_rsp1_quiet", a1.rsp_valid, 0);
    // fixed priority: port 1 starves while port 0 keeps valid high
    b0.req_valid = 1'b1; b0.req_addr = 16'h0004;
    b1.req_valid = 1'b1; b1.req_addr = 16'h0008;
    #1;
    chk("fp1_ready0", b0.req_ready, 1);
    chk("fp1_ready1", b1.req_ready, 0);
    tick();
    tick();
    chk("fp2_ready0", b0.req_ready, 1);
    chk("fp2_ready1", b1.req_ready, 0);
    tick();
    chk("fp_rsp0_valid", b0.rsp_valid, 1);
    chk("fp_rsp1_quiet", b1.rsp_valid, 0);
    tick();
    b0.req_valid = 1'b0;
    #1;
    chk("fp3_ready1", b1.req_ready, 1);
    chk("fp3_ready0", b0.req_ready, 0);
    chk("fp_read_en", re_b, 1);
    tick();
    b1.req_valid = 1'b0;
    tick();
    tick();
    chk("fp_rsp1_valid", b1.rsp_valid, 1);
    chk("fp_rsp1_rdata", b1.rsp_rdata, 16'h1008);
    chk("fp_rsp0_done", b0.rsp_valid, 0);
    chk("fp_write_en_idle", we_b, 0);
    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
